fifo_rd_sched: RTL and testbench
================================

# fifo_rd_sched

Read-side scheduler for the asynchronous FIFO, in the rd_clk domain. It shares the FIFO read port among NUM_REQ consumers using round-robin bursts and drives the FIFO's read enable. It captures read data, which arrives one cycle after the read, into a 2-entry output buffer. Data is delivered on a valid/ready channel to the currently granted consumer.

## Interface
- DATA_WD, 8, FIFO data width
- NUM_REQ, 4, number of requesters (2..8)
- BURST_MAX, 4, max words per grant (1..15)

- rd_clk  in  1  read-domain clock
- rd_rstn  in  1  reset, asynchronous, active-low
- req_i  in  NUM_REQ  per-consumer request level
- gnt_o  out  NUM_REQ  one-hot grant, registered; identifies destination of dout_o
- rd_en_o  out  1  FIFO read enable (combinational from registered state, rd_empty_i, dout_ready_i)
- rd_empty_i  in  1  FIFO empty flag
- rd_data_i  in  DATA_WD  FIFO read data, valid the cycle after rd_en_o
- dout_o  out  DATA_WD  buffer head data
- dout_valid_o  out  1  buffer non-empty
- dout_ready_i  in  1  granted consumer accepts
- burst_done_o  out  1  one-cycle pulse when grant released
- busy_o  out  1  state != IDLE

## Operation
- Reset values: state IDLE, gnt_o=0, rd_en_o=0, dout_valid_o=0, dout_o=0, burst_done_o=0, busy_o=0, rr_ptr=NUM_REQ-1 (req 0 wins first), buf_cnt=0, inflight=0, issued=0.
- States: IDLE, BURST, DRAIN.
- IDLE: if |req_i and !rd_empty_i, select first set req_i index scanning from rr_ptr+1 (mod NUM_REQ). Set gnt_o one-hot, clear issued, go BURST. No arbitration while FIFO is empty.
- pop = dout_valid_o & dout_ready_i.
- BURST: rd_en_o = !rd_empty_i & req_i[g] & (issued < BURST_MAX) & ((buf_cnt + inflight) < 2 | pop).
  - Each rd_en_o increments issued.
  - inflight <= rd_en_o.
  - If inflight, rd_data_i is pushed into the buffer.
- BURST -> DRAIN when any of the following holds:
  - issued reaches BURST_MAX, counting the read issued this cycle;
  - req_i[g] is low;
  - rd_empty_i is high with no rd_en_o this cycle.
- DRAIN: rd_en_o=0. When inflight=0 and buf_cnt=0:
  - clear gnt_o;
  - rr_ptr <= g;
  - pulse burst_done_o;
  - go IDLE.
- Words already read are always delivered to the granted consumer, even if its req_i dropped.
- Buffer is a 2-entry FIFO, buf_cnt 0..2.
  - Push and pop in the same cycle leave buf_cnt unchanged.
  - Overflow is impossible by construction of rd_en_o; a bench assertion checks this.
- Reset mid-operation: buffered and in-flight words are discarded. Those FIFO words are consumed and lost; this is accepted behaviour.
- rd_en_o is never high in IDLE or DRAIN, or while rd_empty_i=1.

## Timing
- Request latency:
  - cycle t: req_i high and FIFO non-empty in IDLE;
  - t+1: gnt_o valid, first rd_en_o possible;
  - t+2: first dout_valid_o.
- Throughput is 1 word/cycle while dout_ready_i=1 and the FIFO is non-empty.
- With dout_ready_i=0: at most 2 words are buffered (buf_cnt + inflight <= 2), then rd_en_o stops.
- Release: burst_done_o is high in the same cycle gnt_o falls to 0. The next grant is possible the following cycle, making 1 idle cycle between bursts.
- gnt_o is stable for the whole BURST+DRAIN period.

## Test plan
- FIFO holds 10 words, req_i=4'b0001, ready=1 -> rd_en_o high 4 consecutive cycles starting at t+1; dout_valid_o on 4 words at t+2..t+5; burst_done_o pulse; regrant to req 0 after 1 idle cycle.
- req_i=4'b1111, FIFO continuously non-empty -> grants in order 0,1,2,3,0 with 4 words each; gnt_o never multi-hot.
- Grant req 2, hold dout_ready_i=0 -> exactly 2 rd_en_o then stall, buf_cnt=2; release ready -> remaining 2 words read; total 4 delivered in order.
- FIFO has 2 words, BURST_MAX=4, req 1 -> 2 reads, empty ends burst; DRAIN delivers 2 words; no rd_en_o while rd_empty_i=1.
- req_i[g] dropped after the 1st rd_en_o -> no further reads; in-flight word still delivered with gnt_o[g]=1; then burst_done_o.
- Assert rd_rstn=0 mid-burst with buf_cnt=2 -> all outputs at reset values immediately; after release, req 0 wins the first grant.

Source files
------------

// File: rtl/fifo_rd_sched.sv
// Read-side scheduler for the async FIFO: round-robin burst grants, FIFO read enable,
// and a 2-entry output buffer that delivers read data to the granted consumer.
module fifo_rd_sched #(
  parameter int DATA_WD   = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 4
) (
  input  logic               rd_clk,
  input  logic               rd_rstn,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               rd_en_o,
  input  logic               rd_empty_i,
  input  logic [DATA_WD-1:0] rd_data_i,
  output logic [DATA_WD-1:0] dout_o,
  output logic               dout_valid_o,
  input  logic               dout_ready_i,
  output logic               burst_done_o,
  output logic               busy_o
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int IW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                      state;
  logic [PW-1:0]               rr_ptr, g_idx, arb_idx, cand;
  logic                        arb_hit;
  logic [IW-1:0]               issued;
  logic                        inflight;
  logic [1:0]                  buf_cnt;
  logic [1:0][DATA_WD-1:0]     buf_q;
  logic                        pop, req_g, room, last_rd;

  // Scan downwards so the nearest index after rr_ptr is the final winner.
  always_comb begin
    arb_idx = '0;
    arb_hit = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_i[cand]) begin
        arb_idx = cand;
        arb_hit = 1'b1;
      end
    end
  end

  assign pop     = dout_valid_o & dout_ready_i;
  assign req_g   = req_i[g_idx];
  assign room    = (buf_cnt + 2'(inflight)) < 2'd2;
  assign rd_en_o = (state == BURST) & ~rd_empty_i & req_g &
                   (issued < IW'(BURST_MAX)) & (room | pop);
  assign last_rd = (issued + IW'(rd_en_o)) >= IW'(BURST_MAX);
  assign busy_o  = (state != IDLE);

  // The in-flight word is visible straight away so the first word lands at t+2.
  assign dout_valid_o = (buf_cnt != 2'd0) | inflight;
  assign dout_o       = (buf_cnt == 2'd0 && inflight) ? rd_data_i : buf_q[0];

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      buf_cnt  <= 2'd0;
      buf_q    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en_o;
      case ({inflight, pop})
        2'b10: begin
          buf_q[buf_cnt[0]] <= rd_data_i;
          buf_cnt           <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          buf_cnt  <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_q[0] <= rd_data_i;
          end else if (buf_cnt == 2'd2) begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= rd_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      state        <= IDLE;
      gnt_o        <= '0;
      g_idx        <= '0;
      rr_ptr       <= PW'(NUM_REQ - 1);
      issued       <= '0;
      burst_done_o <= 1'b0;
    end else begin
      burst_done_o <= 1'b0;
      case (state)
        IDLE: if (arb_hit && !rd_empty_i) begin
          g_idx  <= arb_idx;
          gnt_o  <= NUM_REQ'(1) << arb_idx;
          issued <= '0;
          state  <= BURST;
        end
        BURST: begin
          issued <= issued + IW'(rd_en_o);
          if (last_rd || !req_g || rd_empty_i) state <= DRAIN;
        end
        DRAIN: if (!inflight && buf_cnt == 2'd0) begin
          gnt_o        <= '0;
          rr_ptr       <= g_idx;
          burst_done_o <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: the bench acts as the FIFO and consumers, and a queue-based
// model of grants and pending words is compared against the DUT every cycle.
module tb_fifo_rd_sched;
  localparam int DW = 8, NR = 4, BM = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rstn;
  logic [NR-1:0] req_i, gnt_o;
  logic          rd_en_o, rd_empty_i, dout_valid_o, dout_ready_i, burst_done_o, busy_o;
  logic [DW-1:0] rd_data_i, dout_o;

  fifo_rd_sched #(.DATA_WD(DW), .NUM_REQ(NR), .BURST_MAX(BM)) dut (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .req_i(req_i), .gnt_o(gnt_o),
    .rd_en_o(rd_en_o), .rd_empty_i(rd_empty_i), .rd_data_i(rd_data_i),
    .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
    .burst_done_o(burst_done_o), .busy_o(busy_o)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0, failures = 0, cyc = 0;
  logic [DW-1:0] fifo[$], pend[$];

  // model: phase 0 idle / 1 reading / 2 draining, granted index, rr pointer, reads this burst
  int m_state, m_g, m_ptr, m_issued;
  bit m_bd;

  bit            c_rd, c_ready, c_empty;
  logic [NR-1:0] c_req;
  int            c_psz;

  logic [NR-1:0] req_v;
  bit            ready_v;
  int            prod_pct;

  bit            lg_rd[$], lg_val[$], lg_bd[$], lg_pop[$];
  logic [NR-1:0] lg_gnt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d bound expired", name, cyc);
  endtask

  function automatic int sum_q(input bit q[$], input int a, input int b);
    int s = 0;
    for (int i = a; i <= b && i < q.size(); i++) s += int'(q[i]);
    return s;
  endfunction

  task automatic model_reset();
    m_state = 0; m_g = 0; m_ptr = NR - 1; m_issued = 0; m_bd = 0;
    pend.delete();
    c_rd = 0; c_ready = 0; c_empty = 1; c_req = '0; c_psz = 0;
  endtask

  // Apply the effect of the clock edge that closed the previous cycle.
  task automatic model_edge();
    logic [DW-1:0] w;
    if (!rd_rstn) begin
      model_reset();
      rd_data_i = DW'($urandom);
      return;
    end
    m_bd = 0;
    if (pend.size() > 0 && c_ready) void'(pend.pop_front());
    if (c_rd) begin
      w = (fifo.size() > 0) ? fifo.pop_front() : '0;
      pend.push_back(w);
      rd_data_i = w;
      checks++;
      if (pend.size() > 2) begin
        failures++;
        $display("FAIL overflow cyc=%0d pending=%0d limit=2", cyc, pend.size());
      end
    end else begin
      rd_data_i = DW'($urandom);
    end
    case (m_state)
      0: if (c_req != '0 && !c_empty) begin
        for (int i = 1; i <= NR; i++)
          if (c_req[(m_ptr + i) % NR]) begin m_g = (m_ptr + i) % NR; break; end
        m_issued = 0;
        m_state  = 1;
      end
      1: begin
        if (c_rd) m_issued++;
        if (m_issued >= BM || !c_req[m_g] || c_empty) m_state = 2;
      end
      default: if (c_psz == 0) begin
        m_ptr = m_g; m_bd = 1; m_state = 0;
      end
    endcase
  endtask

  task automatic compare();
    bit e_rd, e_val;
    logic [NR-1:0] e_gnt;
    e_gnt = (m_state != 0) ? (NR'(1) << m_g) : '0;
    e_val = pend.size() > 0;
    e_rd  = (m_state == 1) && !rd_empty_i && req_i[m_g] && (m_issued < BM) &&
            (pend.size() < 2 || (e_val && dout_ready_i));
    chk("gnt", 32'(gnt_o), 32'(e_gnt));
    chk("rd_en", 32'(rd_en_o), 32'(e_rd));
    chk("dout_valid", 32'(dout_valid_o), 32'(e_val));
    if (e_val) chk("dout", 32'(dout_o), 32'(pend[0]));
    chk("burst_done", 32'(burst_done_o), 32'(m_bd));
    chk("busy", 32'(busy_o), 32'(m_state != 0));
    c_rd = rd_en_o; c_ready = dout_ready_i; c_empty = rd_empty_i; c_req = req_i;
    c_psz = pend.size();
    lg_rd.push_back(rd_en_o); lg_val.push_back(dout_valid_o); lg_bd.push_back(burst_done_o);
    lg_pop.push_back(dout_valid_o & dout_ready_i); lg_gnt.push_back(gnt_o);
  endtask

  task automatic step();
    @(negedge rd_clk);
    model_edge();
    if ($urandom_range(99) < prod_pct && fifo.size() < 24) fifo.push_back(DW'($urandom));
    req_i = req_v; dout_ready_i = ready_v; rd_empty_i = (fifo.size() == 0);
    #1;
    compare();
    cyc++;
  endtask

  task automatic go_idle();
    int n = 0;
    req_v = '0; ready_v = 1; prod_pct = 0;
    do begin step(); n++; end while ((busy_o || m_state != 0) && n < 40);
    if (busy_o || m_state != 0) fail_now("idle_timeout");
    fifo.delete();
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) fifo.push_back(DW'($urandom));
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_o), 32'h0);
    chk({tag, "_rd_en"}, 32'(rd_en_o), 32'h0);
    chk({tag, "_valid"}, 32'(dout_valid_o), 32'h0);
    chk({tag, "_dout"}, 32'(dout_o), 32'h0);
    chk({tag, "_bdone"}, 32'(burst_done_o), 32'h0);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n, nb;
    int gseq[$], rdc[$];
    logic [NR-1:0] prev;
    rd_rstn = 0; req_i = '0; dout_ready_i = 0; rd_empty_i = 1; rd_data_i = '0;
    req_v = '0; ready_v = 0; prod_pct = 0;
    model_reset();
    #1;
    check_reset_outs("reset");
    step(); step();
    rd_rstn = 1;

    // Rotation: all requesting, FIFO never empty -> 0,1,2,3,0 with BM words each.
    preload(40); req_v = '1; ready_v = 1;
    prev = '0; n = 0;
    while (gseq.size() < 5 && n < 80) begin
      step(); n++;
      if (prev == '0 && gnt_o != '0) begin gseq.push_back(int'(gnt_o)); rdc.push_back(0); end
      if (gnt_o != '0 && rd_en_o) rdc[rdc.size()-1]++;
      prev = gnt_o;
    end
    if (gseq.size() < 5) fail_now("rotation_timeout");
    else begin
      chk("rot_g0", gseq[0], 1); chk("rot_g1", gseq[1], 2); chk("rot_g2", gseq[2], 4);
      chk("rot_g3", gseq[3], 8); chk("rot_g4", gseq[4], 1);
      for (int i = 0; i < 4; i++) chk("rot_words", rdc[i], BM);
    end
    go_idle();

    // Single requester with 10 words: latency, burst length, release, regrant.
    preload(10); req_v = 4'b0001; ready_v = 1;
    t0 = cyc;
    for (int i = 0; i < 9; i++) step();
    chk("a_rd_pattern", {lg_rd[t0], lg_rd[t0+1], lg_rd[t0+2], lg_rd[t0+3], lg_rd[t0+4], lg_rd[t0+5]},
        6'b011110);
    chk("a_val_pattern", {lg_val[t0+1], lg_val[t0+2], lg_val[t0+5], lg_val[t0+6]}, 4'b0110);
    chk("a_gnt_t1", 32'(lg_gnt[t0+1]), 32'h1);
    chk("a_bdone", 32'(lg_bd[t0+7]), 32'h1);
    chk("a_gnt_released", 32'(lg_gnt[t0+7]), 32'h0);
    chk("a_regrant", 32'(lg_gnt[t0+8]), 32'h1);
    go_idle();

    // Backpressure: ready low -> exactly two reads, then release the remaining two.
    preload(10); req_v = 4'b0100; ready_v = 0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) step();
    chk("c_stall_reads", sum_q(lg_rd, t0, cyc - 1), 2);
    chk("c_stall_valid", 32'(dout_valid_o), 32'h1);
    ready_v = 1; n = 0;
    do begin step(); n++; end while (!burst_done_o && n < 30);
    if (!burst_done_o) fail_now("c_done_timeout");
    chk("c_burst_reads", sum_q(lg_rd, t0, cyc - 1), 4);
    chk("c_delivered", sum_q(lg_pop, t0, cyc - 1), 4);
    go_idle();

    // Only 2 words available: empty FIFO ends the burst early.
    preload(2); req_v = 4'b0010; ready_v = 1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) step();
    chk("d_reads", sum_q(lg_rd, t0, cyc - 1), 2);
    chk("d_delivered", sum_q(lg_pop, t0, cyc - 1), 2);
    chk("d_bdone", sum_q(lg_bd, t0, cyc - 1), 1);
    go_idle();

    // Request dropped right after the first read: in-flight word still delivered.
    preload(10); req_v = 4'b1000; ready_v = 1;
    t0 = cyc; n = 0;
    do begin step(); n++; end while (!rd_en_o && n < 10);
    if (!rd_en_o) fail_now("e_read_timeout");
    req_v = '0;
    step();
    chk("e_pop_gnt", 32'(gnt_o), 32'h8);
    chk("e_pop_valid", 32'(dout_valid_o), 32'h1);
    for (int i = 0; i < 6; i++) step();
    chk("e_reads", sum_q(lg_rd, t0, cyc - 1), 1);
    chk("e_delivered", sum_q(lg_pop, t0, cyc - 1), 1);
    chk("e_bdone", sum_q(lg_bd, t0, cyc - 1), 1);
    go_idle();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) prod_pct = (i % 300 == 0) ? 20 : ((i % 300 == 100) ? 60 : 100);
      if ($urandom_range(7) == 0) req_v = NR'($urandom_range(0, (1 << NR) - 1));
      ready_v = ($urandom_range(99) < 75);
      step();
    end
    go_idle();

    // Reset in the middle of a burst with both buffer entries full.
    preload(10); req_v = '1; ready_v = 0;
    t0 = cyc;
    for (int i = 0; i < 6; i++) step();
    chk("f_pre_reads", sum_q(lg_rd, t0, cyc - 1), 2);
    chk("f_pre_valid", 32'(dout_valid_o), 32'h1);
    rd_rstn = 0;
    #1;
    check_reset_outs("midrst");
    model_reset();
    ready_v = 1;
    step(); step();
    rd_rstn = 1;
    n = 0; nb = 0;
    do begin step(); n++; end while (gnt_o == '0 && n < 10);
    if (gnt_o == '0) fail_now("f_grant_timeout");
    else chk("f_first_grant", 32'(gnt_o), 32'h1);
    for (int i = 0; i < 10; i++) step();
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
